if_id_fifo: RTL
===============

IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 Parameter PC_W, default 64, width of PC field.
REQ-002 Parameter INSTR_W, default 32, width of instruction field.
REQ-003 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-004 Port clk  input  1  single clock; all state updates on posedge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port in_valid  input  1  IF presents an entry.
REQ-007 Port in_ready  output  1  FIFO can accept an entry.
REQ-008 Port in_pc  input  PC_W  fetch PC.
REQ-009 Port in_instr  input  INSTR_W  fetched instruction.
REQ-010 Port in_pred  input  1  branch-prediction bit for the entry.
REQ-011 Port flush  input  1  discard all entries (mispredict/redirect).
REQ-012 Port out_valid  output  1  head entry available to ID.
REQ-013 Port out_ready  input  1  ID consumes head this cycle.
REQ-014 Port out_pc  output  PC_W  head PC.
REQ-015 Port out_instr  output  INSTR_W  head instruction.
REQ-016 Port out_pred  output  1  head prediction bit.
REQ-017 Port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-018 Push occurs when in_valid && in_ready && !flush; writes {in_pc, in_instr, in_pred} at tail, tail advances by 1 mod DEPTH.
REQ-019 Pop occurs when out_valid && out_ready && !flush; head advances by 1 mod DEPTH.
REQ-020 in_ready = (count != DEPTH); in_ready depends only on registered state, never on out_ready or in_valid.
REQ-021 out_valid = (count != 0); registered-state only.
REQ-022 out_pc/out_instr/out_pred show the head entry when out_valid=1; all-zero (NOP bubble) when out_valid=0.
REQ-023 Latency: entry pushed at edge N appears on outputs after edge N when FIFO was empty; no combinational in->out bypass.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; legal at any occupancy 1..DEPTH-1.
REQ-025 Full (count=DEPTH): in_ready=0, push ignored even if out_ready=1 same cycle; capacity frees the following cycle.
REQ-026 Empty (count=0): pop ignored; out_ready has no effect.
REQ-027 count update: +1 push only, -1 pop only, unchanged otherwise; never exceeds DEPTH or underflows.
REQ-028 Pointer wrap: head/tail wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-029 Flush=1 at an edge: head=tail=0, count=0 after the edge; same-cycle push and pop both discarded.
REQ-030 Entry order preserved: outputs appear in exact push order, fields of an entry never mixed across entries.
REQ-031 Storage array needs no reset; visible outputs are masked by out_valid per REQ-022.

Reset
REQ-032 rst_n=0 at an edge: head=0, tail=0, count=0; hence out_valid=0, in_ready=1, outputs all-zero after the edge.
REQ-033 Reset has priority over flush, push and pop in the same cycle.
REQ-034 Reset mid-operation discards all stored entries; no pre-reset entry ever appears on outputs afterward.

Verification
REQ-035 Reset then idle: rst_n=0 one cycle -> out_valid=0, in_ready=1, count=0, out_instr=0.
REQ-036 Fill: out_ready=0, push pc=0x1000,0x1004,0x1008,0x100C -> count=4, in_ready=0; 5th push (pc=0x1010) dropped; drain yields 0x1000..0x100C in order, then out_valid=0.
REQ-037 Streaming: in_valid=1, out_ready=1 continuously, 10 sequential PCs -> each appears one cycle after push, count stays 1, pointers wrap twice with no loss.
REQ-038 Full with pop: count=4, in_valid=1, out_ready=1 -> pop accepted, push rejected, count=3; next cycle push accepted, count=3.
REQ-039 Flush with simultaneous push/pop at count=2 -> count=0, out_valid=0, out_instr=0 next cycle; pushed entry never appears.
REQ-040 Reset mid-stream at count=3 with flush=1 asserted -> count=0, in_ready=1; subsequent push of pc=0x2000, in_pred=1 emerges with out_pred=1 one cycle later.

Source files
------------

// File: rtl/if_id_fifo.sv
// rtl/if_id_fifo.sv - IF/ID decoupling FIFO carrying {pc, instr, pred} with flush
module if_id_fifo #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       in_pred,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic                       out_pred,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int ENT_W = PC_W + INSTR_W + 1;

  logic [ENT_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head_ent;

  // Handshake flags come only from registered occupancy, so there is no in->out path.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; stale contents are hidden by the out_valid mask below.
  always_ff @(posedge clk) begin
    if (rst_n && push) entries[tail_q] <= {in_pc, in_instr, in_pred};
  end

  assign head_ent  = out_valid ? entries[head_q] : '0;
  assign out_pc    = head_ent[ENT_W-1 -: PC_W];
  assign out_instr = head_ent[INSTR_W:1];
  assign out_pred  = head_ent[0];

endmodule
